// File: rtl/alu_arbiter_if.sv
// Client and ALU-side signal bundle for alu_arbiter.
// slave = arbiter side, master = clients plus ALU datapath.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [OPW-1:0]   op0;
  logic [OPW-1:0]   op1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             grant;
  logic             busy;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1,
    input  alu_result, alu_zero,
    output ack0, ack1, result, zero, grant, busy,
    output alu_a, alu_b, alu_op
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1,
    output alu_result, alu_zero,
    input  ack0, ack1, result, zero, grant, busy,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU (IDLE/EXEC/DONE).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic             win;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = !bus.req0;
`else
  logic last;
  // On a tie the requester that was not served last wins.
  assign win = (bus.req0 && bus.req1) ? !last : bus.req1;
`endif

  assign sel_a  = win ? bus.a1  : bus.a0;
  assign sel_b  = win ? bus.b1  : bus.b0;
  assign sel_op = win ? bus.op1 : bus.op0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.grant  <= 1'b0;
      bus.result <= '0;
      bus.zero   <= 1'b0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            bus.alu_a  <= sel_a;
            bus.alu_b  <= sel_b;
            bus.alu_op <= sel_op;
            bus.grant  <= win;
            bus.busy   <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.result <= bus.alu_result;
          bus.zero   <= bus.alu_zero;
          bus.ack0   <= !bus.grant;
          bus.ack1   <= bus.grant;
          state      <= DONE;
        end
        DONE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last     <= bus.grant;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level model
// checked every cycle on the falling edge.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   npass = 0;
  int   ntot = 0;

  alu_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return a << b[4:0];
      3'd5:    return a >> b[4:0];
      3'd6:    return a - b;
      default: return {31'b0, $signed(a) < $signed(b)};
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Transaction model: one operation in flight, scheduled by cycle index.
  int          cnt, idle_from, t_exec;
  logic        m_last, e_grant, e_busy, e_ack0, e_ack1, e_zero;
  logic [31:0] e_a, e_b, e_result;
  logic [2:0]  e_op;

  task automatic model_reset();
    cnt = 0; idle_from = 0; t_exec = -100;
    m_last = 1'b1; e_grant = 1'b0; e_busy = 1'b0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_zero = 1'b0;
    e_a = '0; e_b = '0; e_op = '0; e_result = '0;
  endtask

  task automatic model_step();
    int  k;
    logic w;
    k = cnt + 1;
    if (cnt >= idle_from && (bus.req0 || bus.req1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = bus.req0 ? 1'b0 : 1'b1;
`else
      if (bus.req0 && bus.req1) w = !m_last;
      else w = bus.req1;
`endif
      e_grant = w;
      e_a  = w ? bus.a1  : bus.a0;
      e_b  = w ? bus.b1  : bus.b0;
      e_op = w ? bus.op1 : bus.op0;
      m_last = w;
      t_exec = k;
      idle_from = k + 2;
    end
    e_busy = (k >= t_exec) && (k < idle_from);
    e_ack0 = (k == t_exec + 1) && !e_grant;
    e_ack1 = (k == t_exec + 1) && e_grant;
    if (k == t_exec + 1) begin
      e_result = alu_f(e_op, e_a, e_b);
      e_zero   = (e_result == 32'd0);
    end
    cnt = k;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else begin
        chk("ack0",   {31'b0, bus.ack0},  {31'b0, e_ack0});
        chk("ack1",   {31'b0, bus.ack1},  {31'b0, e_ack1});
        chk("busy",   {31'b0, bus.busy},  {31'b0, e_busy});
        chk("grant",  {31'b0, bus.grant}, {31'b0, e_grant});
        chk("result", bus.result, e_result);
        chk("zero",   {31'b0, bus.zero},  {31'b0, e_zero});
        chk("alu_a",  bus.alu_a, e_a);
        chk("alu_b",  bus.alu_b, e_b);
        chk("alu_op", {29'b0, bus.alu_op}, {29'b0, e_op});
        model_step();
      end
    end
  end

  task automatic wait_ack(input bit who, output int edges);
    bit seen;
    seen = 1'b0;
    edges = 0;
    while (!seen && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      seen = who ? bus.ack1 : bus.ack0;
    end
    if (!seen) begin
      ntot++;
      $display("FAIL ack_timeout: req%0d got no ack, required one", who);
    end
  endtask

  task automatic set_ops(input bit who, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (who) begin bus.a1 = a; bus.b1 = b; bus.op1 = op; end
    else     begin bus.a0 = a; bus.b0 = b; bus.op0 = op; end
  endtask

  task automatic run_one(input string nm, input bit who,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] er,
                         input logic ez);
    int e;
    set_ops(who, a, b, op);
    if (who) bus.req1 = 1'b1; else bus.req0 = 1'b1;
    wait_ack(who, e);
    chk({nm, "_lat"}, e, 2);
    chk({nm, "_res"}, bus.result, er);
    chk({nm, "_zero"}, {31'b0, bus.zero}, {31'b0, ez});
    chk({nm, "_grant"}, {31'b0, bus.grant}, {31'b0, who});
    @(posedge clk); #1;
    if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  typedef struct {
    bit          who;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  vec_t vecs[6] = '{
    '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 32'h00F0_00F0, 1'b0},
    '{1'b1, 32'h1,         32'h4,         3'd4, 32'h10,        1'b0},
    '{1'b0, 32'h8000_0000, 32'd31,        3'd5, 32'h1,         1'b0},
    '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'h0,         1'b1},
    '{1'b0, 32'hFFFF_FFFF, 32'h1,         3'd2, 32'h0,         1'b1},
    '{1'b1, 32'd3,         32'd5,         3'd7, 32'h1,         1'b0}
  };

  initial begin
    int e, got;
    bit seq[4];
    bit exp_seq[4];
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.op0 = 0;
    bus.a1 = 0; bus.b1 = 0; bus.op1 = 0;
    @(posedge clk); #1;
    chk("rst_ack0",   {31'b0, bus.ack0}, 0);
    chk("rst_busy",   {31'b0, bus.busy}, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_alu_a",  bus.alu_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_one("add", 1'b0, 32'd5, 32'd3, 3'd2, 32'd8, 1'b0);
    run_one("sub_zero", 1'b1, 32'd7, 32'd7, 3'd6, 32'd0, 1'b1);

    // Tie: both held for four grants.
    set_ops(1'b0, 32'd10, 32'd4, 3'd6);
    set_ops(1'b1, 32'd3,  32'd4, 3'd1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      @(posedge clk); #1;
      if (bus.ack0 || bus.ack1) begin
        seq[got] = bus.ack1;
        chk("tie_res", bus.result, bus.ack1 ? 32'd7 : 32'd6);
        got++;
      end
    end
    chk("tie_count", got, 4);
    for (int i = 0; i < 4; i++)
      chk("tie_order", {31'b0, seq[i]}, {31'b0, exp_seq[i]});
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    wait_ack(1'b1, e);
    chk("tie_tail_lat", e, 2);
    chk("tie_tail_res", bus.result, 32'd7);
    @(posedge clk); #1;
    bus.req1 = 1'b0;

    // Operand change during EXEC must not reach the result.
    set_ops(1'b0, 32'd5, 32'd3, 3'd2);
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    chk("iso_busy", {31'b0, bus.busy}, 1);
    chk("iso_alu_a", bus.alu_a, 32'd5);
    bus.a0 = 32'd9;
    wait_ack(1'b0, e);
    chk("iso_lat", e, 1);
    chk("iso_res", bus.result, 32'd8);
    chk("iso_alu_a_hold", bus.alu_a, 32'd5);
    @(posedge clk); #1;
    bus.req0 = 1'b0;

    // Reset in EXEC aborts the operation.
    set_ops(1'b0, 32'd20, 32'd22, 3'd2);
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", {31'b0, bus.busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ack0",   {31'b0, bus.ack0}, 0);
    chk("mid_busy0",  {31'b0, bus.busy}, 0);
    chk("mid_grant",  {31'b0, bus.grant}, 0);
    chk("mid_result", bus.result, 0);
    chk("mid_zero",   {31'b0, bus.zero}, 0);
    chk("mid_alu_a",  bus.alu_a, 0);
    chk("mid_alu_b",  bus.alu_b, 0);
    chk("mid_alu_op", {29'b0, bus.alu_op}, 0);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    chk("mid_noack", {31'b0, bus.ack0}, 0);
    rst_n = 1'b1;
    run_one("reissue", 1'b0, 32'd20, 32'd22, 3'd2, 32'd42, 1'b0);

    foreach (vecs[i])
      run_one("vec", vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].er, vecs[i].ez);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing arbiter that shares one combinational 32-bit ALU (with its operand muxes) between two requesters. It accepts level-held requests, picks a winner, and drives the winner's operands and opcode onto the shared ALU port. It registers the ALU result and zero flag, then returns them with a one-cycle acknowledge to the granted requester. It sits between the two client blocks and the ALU datapath, and is the only driver of the ALU inputs.

## Interface
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  request, level; held until matching ack
- a0, b0, a1, b1  in  WIDTH  requester operands, sampled only at grant edge
- op0, op1  in  OPW  requester opcode, sampled only at grant edge
- ack0, ack1  out  1  one-cycle completion pulse to requester 0/1
- result  out  WIDTH  registered ALU result, valid while ack high, held afterwards
- zero  out  1  registered ALU zero flag, same validity as result
- grant  out  1  index of the current/last granted requester
- busy  out  1  high in EXEC and DONE
- alu_a, alu_b  out  WIDTH  registered operands to the shared ALU
- alu_op  out  OPW  registered opcode to the shared ALU
- alu_result  in  WIDTH  combinational ALU output
- alu_zero  in  1  combinational ALU zero flag

## Operation
- FSM states: IDLE, EXEC, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Any request sampled: choose a winner, latch its a/b/op into alu_a/alu_b/alu_op, set grant, go to EXEC.
- EXEC:
  - Operands are stable for the full cycle so the ALU settles.
  - At the closing edge, capture alu_result into result and alu_zero into zero.
  - Assert ack[grant] for the next cycle and go to DONE.
- DONE:
  - ack[grant] is high for exactly this cycle.
  - Update the round-robin pointer last := grant, then go to IDLE.
- Arbitration, when both requests are high in IDLE: grant the requester that is not `last`. A single request is always granted.
- Requester rule:
  - Deassert req on the edge that samples ack high.
  - A req still high in IDLE after its ack is treated as a new request.
- Requests and operands arriving in EXEC/DONE are ignored until IDLE. No request is lost while its req is held.
- Unused requester's ack stays 0. Only one ack is high at a time; ack0 and ack1 are never high together.
- Opcode is passed through without decoding. Any OPW value is legal.

## Timing
- Reset values:
  - state = IDLE
  - ack0 = ack1 = 0, busy = 0, grant = 0
  - result = 0, zero = 0
  - alu_a = alu_b = 0, alu_op = 0
  - last = 1, so requester 0 wins the first tie.
- Latency:
  - Grant edge E0 → EXEC for cycle E0..E1 → ack high for cycle E1..E2.
  - ack is seen 2 edges after the grant edge.
- Throughput: one operation per 3 cycles. Back-to-back requests from alternating requesters are granted in consecutive IDLE cycles.
- Reset mid-operation (EXEC or DONE): abort immediately.
  - No ack is issued, and all outputs take their reset values asynchronously.
  - The request must be reissued by the client after reset releases.
- Reset deassertion is applied synchronously by the integrator. The first IDLE sample is on the first rising edge with rst_n high.

## Configuration
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins a tie, and `last` is neither updated nor used.
- Undefined (default): round-robin as specified in Operation.
- Latency, handshake and reset behaviour are identical in both builds.

## Test plan
- Reset then single request: req0=1, a0=5, b0=3, op0=add(010), ALU model a+b → ack0 two edges after grant, result=8, zero=0, ack1 never high.
- Zero flag: req1=1, a1=7, b1=7, op1=sub(110) → ack1 high one cycle, result=0, zero=1, grant=1.
- Tie, round-robin build: req0 and req1 held high together for 4 grants → grant order 0,1,0,1; each ack is one cycle; result matches each requester's operands.
- Tie, ALU_ARB_FIXED_PRIO_EN build: same stimulus with req0 re-raised immediately after each ack → grants 0,0,0…; req1 is served only after req0 drops.
- Operand isolation: change a0 from 5 to 9 during EXEC → result still reflects 5; alu_a stays stable through EXEC.
- Reset mid-op: assert rst_n=0 during EXEC → no ack, all outputs 0 immediately, then after release req0 reissued → normal ack with correct result.
